// File: rtl/mul_special_pipe.sv
// Two-stage special-case resolver for an IEEE-style multiplier.
// Stage 1 classifies the operands; stage 2 decides NaN/inf/zero results and the flags.
module mul_special_pipe #(
  parameter int unsigned EXPO_W = 8,
  parameter int unsigned MANT_W = 23,
  parameter bit          DAZ_EN = 1'b0,
  localparam int unsigned W     = 1 + EXPO_W + MANT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a_op,
  input  logic [W-1:0] b_op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         r_special,
  output logic [W-1:0] r_word,
  output logic         r_sign,
  output logic         r_invalid,
  output logic [2:0]   a_cls,
  output logic [2:0]   b_cls
);

  typedef enum logic [2:0] {
    ClsZero = 3'd0,
    ClsSub  = 3'd1,
    ClsNorm = 3'd2,
    ClsInf  = 3'd3,
    ClsQnan = 3'd4,
    ClsSnan = 3'd5
  } cls_e;

  localparam logic [W-1:0] QnanWord = {1'b0, {EXPO_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};
  localparam logic [W-2:0] InfMag   = {{EXPO_W{1'b1}}, {MANT_W{1'b0}}};

  function automatic cls_e classify(input logic [W-1:0] op);
    logic [EXPO_W-1:0] expo;
    logic [MANT_W-1:0] mant;
    cls_e              cls;
    expo = op[W-2 -: EXPO_W];
    mant = op[MANT_W-1:0];
    if (expo == '0) begin
      // With DAZ a subnormal collapses to zero before any rule sees it.
      cls = (mant == '0 || DAZ_EN) ? ClsZero : ClsSub;
    end else if (&expo) begin
      if (mant == '0) begin
        cls = ClsInf;
      end else begin
        cls = mant[MANT_W-1] ? ClsQnan : ClsSnan;
      end
    end else begin
      cls = ClsNorm;
    end
    return cls;
  endfunction

  // Handshake / stage enables
  logic s1_valid_q, s2_valid_q;
  logic s1_en, s2_en;

  assign s2_en    = !s2_valid_q || out_ready;
  assign s1_en    = !s1_valid_q || s2_en;
  assign in_ready = s1_en;

  // Stage 1: operand classes and product sign
  cls_e s1_a_cls_q, s1_b_cls_q;
  logic s1_sign_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_cls_q <= ClsZero;
      s1_b_cls_q <= ClsZero;
      s1_sign_q  <= 1'b0;
    end else if (s1_en) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_a_cls_q <= classify(a_op);
        s1_b_cls_q <= classify(b_op);
        s1_sign_q  <= a_op[W-1] ^ b_op[W-1];
      end
    end
  end

  // Stage 2 next-state: priority NaN > inf*zero > inf > zero > ordinary
  logic         special_d;
  logic [W-1:0] word_d;
  logic         invalid_d;
  logic         a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, any_snan;

  always_comb begin
    a_nan    = (s1_a_cls_q == ClsQnan) || (s1_a_cls_q == ClsSnan);
    b_nan    = (s1_b_cls_q == ClsQnan) || (s1_b_cls_q == ClsSnan);
    a_inf    = (s1_a_cls_q == ClsInf);
    b_inf    = (s1_b_cls_q == ClsInf);
    a_zero   = (s1_a_cls_q == ClsZero);
    b_zero   = (s1_b_cls_q == ClsZero);
    any_snan = (s1_a_cls_q == ClsSnan) || (s1_b_cls_q == ClsSnan);

    special_d = 1'b1;
    word_d    = '0;
    invalid_d = 1'b0;
    if (a_nan || b_nan) begin
      word_d    = QnanWord;
      invalid_d = any_snan;
    end else if ((a_inf && b_zero) || (a_zero && b_inf)) begin
      word_d    = QnanWord;
      invalid_d = 1'b1;
    end else if (a_inf || b_inf) begin
      word_d = {s1_sign_q, InfMag};
    end else if (a_zero || b_zero) begin
      word_d = {s1_sign_q, {(W-1){1'b0}}};
    end else begin
      special_d = 1'b0;
    end
  end

  // Stage 2: registered results, held while the consumer stalls
  logic         r_special_q, r_sign_q, r_invalid_q;
  logic [W-1:0] r_word_q;
  cls_e         r_a_cls_q, r_b_cls_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q  <= 1'b0;
      r_special_q <= 1'b0;
      r_word_q    <= '0;
      r_sign_q    <= 1'b0;
      r_invalid_q <= 1'b0;
      r_a_cls_q   <= ClsZero;
      r_b_cls_q   <= ClsZero;
    end else if (s2_en) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        r_special_q <= special_d;
        r_word_q    <= word_d;
        r_sign_q    <= s1_sign_q;
        r_invalid_q <= invalid_d;
        r_a_cls_q   <= s1_a_cls_q;
        r_b_cls_q   <= s1_b_cls_q;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign r_special = r_special_q;
  assign r_word    = r_word_q;
  assign r_sign    = r_sign_q;
  assign r_invalid = r_invalid_q;
  assign a_cls     = r_a_cls_q;
  assign b_cls     = r_b_cls_q;

endmodule

// File: tb/tb_mul_special_pipe.sv
// Bench for mul_special_pipe: directed special cases, back-pressure, reset flush and
// a random stream scored against a plain-arithmetic reference model.
module tb_mul_special_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready;
  logic [31:0] a_op, b_op;

  logic        in_ready, out_valid, r_special, r_sign, r_invalid;
  logic [31:0] r_word;
  logic [2:0]  a_cls, b_cls;

  logic        d_in_ready, d_out_valid, d_special, d_sign, d_invalid;
  logic [31:0] d_word;
  logic [2:0]  d_a_cls, d_b_cls;

  always #5 clk = ~clk;

  mul_special_pipe #(.EXPO_W(8), .MANT_W(23), .DAZ_EN(1'b0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_op(a_op), .b_op(b_op), .out_valid(out_valid), .out_ready(out_ready),
    .r_special(r_special), .r_word(r_word), .r_sign(r_sign), .r_invalid(r_invalid),
    .a_cls(a_cls), .b_cls(b_cls)
  );

  mul_special_pipe #(.EXPO_W(8), .MANT_W(23), .DAZ_EN(1'b1)) dut_daz (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d_in_ready),
    .a_op(a_op), .b_op(b_op), .out_valid(d_out_valid), .out_ready(out_ready),
    .r_special(d_special), .r_word(d_word), .r_sign(d_sign), .r_invalid(d_invalid),
    .a_cls(d_a_cls), .b_cls(d_b_cls)
  );

  // {special, word, sign, invalid, a_cls, b_cls}
  logic [40:0] obs, d_obs;
  assign obs   = {r_special, r_word, r_sign, r_invalid, a_cls, b_cls};
  assign d_obs = {d_special, d_word, d_sign, d_invalid, d_a_cls, d_b_cls};

  int n_checks = 0;
  int n_errors = 0;
  int n_pops   = 0;
  logic [40:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Class code: 0 zero, 1 subnormal, 2 normal, 3 inf, 4 qNaN, 5 sNaN
  function automatic int cls_of(input logic [31:0] x, input bit daz);
    int e, m;
    e = int'(x[30:23]);
    m = int'(x[22:0]);
    if (e == 0) return (m == 0 || daz) ? 0 : 1;
    if (e == 255) begin
      if (m == 0) return 3;
      return (m >= 32'h400000) ? 4 : 5;
    end
    return 2;
  endfunction

  function automatic logic [40:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input bit daz);
    int          ca, cb;
    logic        sp, sg, inv;
    logic [31:0] w;
    ca  = cls_of(a, daz);
    cb  = cls_of(b, daz);
    sg  = a[31] ^ b[31];
    sp  = 1'b1;
    inv = 1'b0;
    w   = 32'h0;
    if (ca >= 4 || cb >= 4) begin
      w   = 32'h7FC00000;
      inv = (ca == 5 || cb == 5);
    end else if ((ca == 3 && cb == 0) || (ca == 0 && cb == 3)) begin
      w   = 32'h7FC00000;
      inv = 1'b1;
    end else if (ca == 3 || cb == 3) begin
      w = sg ? 32'hFF800000 : 32'h7F800000;
    end else if (ca == 0 || cb == 0) begin
      w = sg ? 32'h80000000 : 32'h00000000;
    end else begin
      sp = 1'b0;
    end
    return {sp, w, sg, inv, 3'(ca), 3'(cb)};
  endfunction

  function automatic logic [31:0] rand_op();
    int          k;
    logic        s;
    logic [22:0] m;
    logic [7:0]  e;
    k = $urandom_range(0, 5);
    s = 1'($urandom);
    m = 23'($urandom_range(1, 32'h7FFFFF));
    e = 8'($urandom_range(1, 254));
    case (k)
      0:       return {s, 31'h0};
      1:       return {s, 8'h00, m};
      2:       return {s, e, m};
      3:       return {s, 8'hFF, 23'h0};
      4:       return {s, 8'hFF, 1'b1, m[21:0]};
      default: return {s, 8'hFF, 1'b0, (m[21:0] == 22'h0) ? 22'h1 : m[21:0]};
    endcase
  endfunction

  // Scoreboard and hold-stability monitor, sampled mid-cycle.
  logic        hold_v = 1'b0;
  logic [40:0] hold_snap;
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_data", 64'(obs), 64'(hold_snap));
      end
      if (out_valid && out_ready) begin
        check("result_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          check("result", 64'(obs), 64'(exp_q.pop_front()));
          n_pops++;
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(a_op, b_op, 1'b0));
      hold_v    = out_valid && !out_ready;
      hold_snap = obs;
    end
  end

  task automatic send_check(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [40:0] exp, input logic [40:0] exp_daz);
    a_op     = a;
    b_op     = b;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check({tag, "_lat1"}, 64'(out_valid), 64'd0);
    step();
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check(tag, 64'(obs), 64'(exp));
    check({tag, "_daz_valid"}, 64'(d_out_valid), 64'd1);
    check({tag, "_daz"}, 64'(d_obs), 64'(exp_daz));
    step();
    step();
  endtask

  initial begin
    logic [31:0] ops[4];
    int          idx, pops0;
    bit          acc, stale;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a_op      = 32'h0;
    b_op      = 32'h0;
    repeat (3) step();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_outs", 64'(obs), 64'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    step();

    // Directed special cases (expected words written straight from the rules)
    send_check("inf_x_zero", 32'h7F800000, 32'h00000000,
               {1'b1, 32'h7FC00000, 1'b0, 1'b1, 3'd3, 3'd0},
               {1'b1, 32'h7FC00000, 1'b0, 1'b1, 3'd3, 3'd0});
    send_check("ninf_x_one", 32'hFF800000, 32'h3F800000,
               {1'b1, 32'hFF800000, 1'b1, 1'b0, 3'd3, 3'd2},
               {1'b1, 32'hFF800000, 1'b1, 1'b0, 3'd3, 3'd2});
    send_check("snan_x_one", 32'h7F800001, 32'h3F800000,
               {1'b1, 32'h7FC00000, 1'b0, 1'b1, 3'd5, 3'd2},
               {1'b1, 32'h7FC00000, 1'b0, 1'b1, 3'd5, 3'd2});
    send_check("sub_x_one", 32'h00000001, 32'h3F800000,
               {1'b0, 32'h00000000, 1'b0, 1'b0, 3'd1, 3'd2},
               {1'b1, 32'h00000000, 1'b0, 1'b0, 3'd0, 3'd2});
    send_check("nqnan_x_inf", 32'hFFC00000, 32'h7F800000,
               {1'b1, 32'h7FC00000, 1'b1, 1'b0, 3'd4, 3'd3},
               {1'b1, 32'h7FC00000, 1'b1, 1'b0, 3'd4, 3'd3});
    send_check("zero_x_ninf", 32'h00000000, 32'hFF800000,
               {1'b1, 32'h7FC00000, 1'b1, 1'b1, 3'd0, 3'd3},
               {1'b1, 32'h7FC00000, 1'b1, 1'b1, 3'd0, 3'd3});
    send_check("nzero_x_two", 32'h80000000, 32'h40000000,
               {1'b1, 32'h80000000, 1'b1, 1'b0, 3'd0, 3'd2},
               {1'b1, 32'h80000000, 1'b1, 1'b0, 3'd0, 3'd2});

    // Back-pressure: four back-to-back operands, consumer stalled at first
    ops   = '{32'h7F800000, 32'h3F800000, 32'h80000000, 32'h7FC00001};
    idx   = 0;
    pops0 = n_pops;
    for (int cyc = 0; cyc < 20; cyc++) begin
      out_ready = (cyc >= 5);
      in_valid  = (idx < 4);
      a_op      = (idx < 4) ? ops[idx] : 32'h0;
      b_op      = 32'h40400000;
      #1;
      if (cyc >= 2 && cyc <= 4) begin
        check("bp_in_ready_low", 64'(in_ready), 64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        check("bp_accepts", 64'(idx), 64'd2);
      end
      acc = in_valid && in_ready;
      step();
      if (acc) idx++;
    end
    in_valid = 1'b0;
    check("bp_all_accepted", 64'(idx), 64'd4);
    check("bp_all_emerged", 64'(n_pops - pops0), 64'd4);

    // Reset with both stages full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a_op      = 32'h7F800000;
    b_op      = 32'h00000000;
    step();
    step();
    in_valid = 1'b0;
    check("full_before_rst", 64'(out_valid), 64'd1);
    rst = 1'b1;
    step();
    check("rst_flush_valid", 64'(out_valid), 64'd0);
    check("rst_flush_outs", 64'(obs), 64'd0);
    rst = 1'b0;
    #1;
    check("rst_flush_in_ready", 64'(in_ready), 64'd1);
    check("rst_flush_daz_in_ready", 64'(d_in_ready), 64'd1);
    out_ready = 1'b1;
    stale     = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (out_valid) stale = 1'b1;
    end
    check("no_stale", 64'(stale), 64'd0);

    // Random stream with random handshakes
    for (int cyc = 0; cyc < 600; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      a_op      = rand_op();
      b_op      = rand_op();
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    check("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
